// File: rtl/ahb_mst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mst_seq
// Brief    : Single-command transfer sequencer in front of an AHB master
//            interface. It paces beats, buffers write data and rewinds on retry.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mst_seq #(
   parameter int LEN_W    = 8,
   parameter int WF_DEPTH = 4
) (
   input  logic             HCLK,
   input  logic             HRST,
   input  logic             CmdValid,
   output logic             CmdReady,
   input  logic             CmdWrite,
   input  logic [2:0]       CmdSize,
   input  logic [31:0]      CmdAddr,
   input  logic [LEN_W-1:0] CmdLen,
   input  logic             WrValid,
   input  logic [31:0]      WrData,
   output logic             WrReady,
   output logic             RdValid,
   output logic [31:0]      RdData,
   output logic             Done,
   output logic             Active,
   output logic             Request,
   output logic             Burst,
   output logic             Busy,
   output logic             Write,
   output logic [2:0]       Size,
   output logic [31:0]      Addr,
   output logic [31:0]      DataIn,
   input  logic [31:0]      DataOut,
   input  logic             Grant,
   input  logic             Okay,
   input  logic             Retry
);

   localparam int               c_AW       = $clog2(WF_DEPTH);
   localparam logic [1:0]       c_ST_IDLE  = 2'd0;
   localparam logic [1:0]       c_ST_RUN   = 2'd1;
   localparam logic [1:0]       c_ST_DRAIN = 2'd2;
   localparam logic [c_AW-1:0]  c_PTR_ONE  = 1;
   localparam logic [c_AW:0]    c_CNT_ONE  = 1;
   localparam logic [c_AW:0]    c_CNT_FULL = (c_AW+1)'(WF_DEPTH);
   localparam logic [LEN_W-1:0] c_LEN_ONE  = 1;

   logic [1:0]       r_state;
   logic             r_write;
   logic [2:0]       r_size;
   logic [31:0]      r_addr;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_issue;
   logic [LEN_W-1:0] r_ack;
   logic             r_done;
   logic             r_rd_valid;
   logic [31:0]      r_rd_data;

   logic [31:0]      r_mem [0:WF_DEPTH-1];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_AW:0]    r_cnt;

   logic             w_idle;
   logic             w_run;
   logic             w_active;
   logic             w_req;
   logic             w_grant;
   logic             w_okay;
   logic             w_retry;
   logic             w_finish;
   logic             w_busy;
   logic             w_wr_ready;
   logic             w_push;
   logic             w_pop;
   logic [LEN_W-1:0] w_outstanding;
   logic [LEN_W-1:0] w_ack_nxt;
   logic [LEN_W-1:0] w_issue_nxt;
   logic [1:0]       w_sz;
   logic [31:0]      w_addr;

   assign w_idle   = (r_state == c_ST_IDLE);
   assign w_run    = (r_state == c_ST_RUN);
   assign w_active = ~w_idle;

   // Bus events outside their legal window are dropped so that
   // AckCnt <= IssueCnt <= Len always holds.
   assign w_req   = w_run & (r_issue < r_len);
   assign w_grant = Grant & w_req;
   assign w_okay  = Okay & w_active & (r_ack < r_issue);
   assign w_retry = Retry & w_active;

   assign w_outstanding = r_issue - r_ack;
   assign w_ack_nxt     = w_okay ? (r_ack + c_LEN_ONE) : r_ack;
   assign w_issue_nxt   = w_retry ? w_ack_nxt
                        : (w_grant ? (r_issue + c_LEN_ONE) : r_issue);
   assign w_finish      = w_okay & (w_ack_nxt == r_len);

   // A word is needed beyond those already owed to outstanding beats.
   assign w_busy = r_write & w_run & (32'(r_cnt) <= 32'(w_outstanding));

   assign w_wr_ready = (r_cnt != c_CNT_FULL);
   assign w_push     = WrValid & w_wr_ready;
   assign w_pop      = w_okay & r_write & (r_cnt != '0);

   always_comb begin
      w_sz = 2'd2;
      case (r_size)
         3'b000:  w_sz = 2'd0;
         3'b001:  w_sz = 2'd1;
         default: w_sz = 2'd2;
      endcase
   end

   assign w_addr = r_addr + (32'(r_ack) << w_sz);

   always_ff @(posedge HCLK) begin
      if (HRST) begin
         r_state    <= c_ST_IDLE;
         r_write    <= 1'b0;
         r_size     <= 3'b000;
         r_addr     <= '0;
         r_len      <= '0;
         r_issue    <= '0;
         r_ack      <= '0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_rd_valid <= w_okay & ~r_write;
         if (w_okay & ~r_write) begin
            r_rd_data <= DataOut;
         end
         case (r_state)
            c_ST_IDLE: begin
               if (CmdValid) begin
                  r_write <= CmdWrite;
                  r_size  <= CmdSize;
                  r_addr  <= CmdAddr;
                  r_len   <= CmdLen;
                  r_issue <= '0;
                  r_ack   <= '0;
                  if (CmdLen == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= c_ST_RUN;
                  end
               end
            end
            default: begin
               r_issue <= w_issue_nxt;
               r_ack   <= w_ack_nxt;
               // A retry in DRAIN rewinds IssueCnt below Len, landing back in RUN.
               if (w_finish) begin
                  r_done  <= 1'b1;
                  r_state <= c_ST_IDLE;
               end else if (w_issue_nxt == r_len) begin
                  r_state <= c_ST_DRAIN;
               end else begin
                  r_state <= c_ST_RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRST) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
            2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_push) begin
         r_mem[r_wptr] <= WrData;
      end
   end

   assign CmdReady = w_idle;
   assign Active   = w_active;
   assign WrReady  = w_wr_ready;
   assign RdValid  = r_rd_valid;
   assign RdData   = r_rd_data;
   assign Done     = r_done;
   assign Request  = w_req;
   assign Burst    = (r_len > c_LEN_ONE);
   assign Busy     = w_busy;
   assign Write    = r_write;
   assign Size     = r_size;
   assign Addr     = w_addr;
   assign DataIn   = r_mem[r_rptr];

endmodule
`default_nettype wire
